ram_loader: RTL

Sequencer that fills the 16×8 program RAM from a byte-stream source before the CPU runs. It accepts bytes over a valid/ready handshake and drives the RAM programming port: address, data, programming mode and write strobe. It holds the CPU off the bus while loading, and reports completion or error. It sits between the front-panel/UART byte source and the RAM's programming inputs.

---
 rtl/ram_loader_pkg.sv | 18 +
 rtl/ram_loader_csum.sv | 31 +++
 rtl/ram_loader.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/ram_loader_pkg.sv
// Shared definitions for the program-RAM loader: default geometry, RAM word
// width and the sequencer state encoding.
package ram_loader_pkg;

  localparam int DEPTH_DEFAULT  = 16;
  localparam int ADDR_W_DEFAULT = 4;
  localparam int RAM_WORD_W     = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    CHECK,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/ram_loader_csum.sv
// Mod-256 running sum of the loaded bytes. The sum is cleared while the loader
// idles, grows by one byte per accepted data byte, and is compared against the
// trailing checksum byte.
module ram_loader_csum
  import ram_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  add,
  input  logic [RAM_WORD_W-1:0] data,
  input  logic [RAM_WORD_W-1:0] cmp,
  output logic                  match
);

  logic [RAM_WORD_W-1:0] sum;

  // Accumulate accepted bytes; overflow wraps naturally to give mod 256.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (add) begin
      sum <= sum + data;
    end
  end

  assign match = (sum == cmp);

endmodule

// File: rtl/ram_loader.sv
// Program-RAM loader: accepts DEPTH bytes over valid/ready, writes them to the
// RAM programming port one word every two cycles, and holds the CPU off the
// bus while doing so.
// Optional feature: define RAM_LOADER_CHECKSUM_EN to require a trailing
// mod-256 checksum byte and enable the sticky error flag.
// ADDR_W must satisfy 2**ADDR_W == DEPTH.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  in_valid,
  input  logic [RAM_WORD_W-1:0] in_data,
  output logic                  in_ready,
  output logic                  prg_mode,
  output logic [ADDR_W-1:0]     prg_addr,
  output logic [RAM_WORD_W-1:0] prg_data,
  output logic                  prg_wr,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t                state;
  state_t                state_next;
  logic [ADDR_W-1:0]     addr_q;
  logic [RAM_WORD_W-1:0] data_q;
  logic                  handshake;

  assign handshake = in_valid && in_ready;
  assign prg_addr  = addr_q;
  assign prg_data  = data_q;

`ifdef RAM_LOADER_CHECKSUM_EN
  logic csum_match;
  logic error_q;

  ram_loader_csum u_csum (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state == IDLE),
    .add   ((state == LOAD) && handshake),
    .data  (in_data),
    .cmp   (in_data),
    .match (csum_match)
  );

  // Sticky checksum error: set on a bad checksum byte, cleared only by a new start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_q <= 1'b0;
    end else if ((state == IDLE) && start) begin
      error_q <= 1'b0;
    end else if ((state == CHECK) && handshake && !csum_match) begin
      error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; abort wins over any handshake in a busy state.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) state_next = LOAD;
      end
      LOAD: begin
        if (abort)          state_next = IDLE;
        else if (in_valid)  state_next = WRITE;
      end
      WRITE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (addr_q == LAST_ADDR) begin
`ifdef RAM_LOADER_CHECKSUM_EN
          state_next = CHECK;
`else
          state_next = DONE;
`endif
        end else begin
          state_next = LOAD;
        end
      end
`ifdef RAM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (abort)          state_next = IDLE;
        else if (in_valid)  state_next = csum_match ? DONE : ERR;
      end
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore-style outputs decoded from the state; in_ready is also masked by abort.
  always_comb begin
    busy     = 1'b0;
    in_ready = 1'b0;
    prg_wr   = 1'b0;
    done     = 1'b0;
    unique case (state)
      LOAD: begin
        busy     = 1'b1;
        in_ready = !abort;
      end
      WRITE: begin
        busy   = 1'b1;
        prg_wr = 1'b1;
      end
      CHECK: begin
        busy     = 1'b1;
        in_ready = !abort;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
    prg_mode = busy;
    cpu_hold = busy;
  end

  // Address counter and data latch; the counter stops at the last word rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      data_q <= '0;
    end else begin
      if (state == IDLE) begin
        addr_q <= '0;
      end else if ((state == WRITE) && !abort && (addr_q != LAST_ADDR)) begin
        addr_q <= addr_q + 1'b1;
      end
      if ((state == LOAD) && handshake) begin
        data_q <= in_data;
      end
    end
  end

endmodule
